uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver; counterpart of the board's UART transmitter.
//  Frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
//  Synchronises the raw RX pin, qualifies the start bit, samples each bit at mid-period
//  and emits each byte with a single-cycle valid strobe. Framing errors are flagged.
//  Sits between the FPGA UART RX pin and byte-level consumers (command parser, FIFO).
// PARAMETERS
//  p_BAUDRATE   9600         line bit rate, bits/s
//  p_CLK_FREQ   12_000_000   i_clk frequency, Hz
//  derived: lp_BIT_PERIOD = p_CLK_FREQ/p_BAUDRATE (integer division, must be >= 4)
//  derived: lp_HALF_PERIOD = lp_BIT_PERIOD/2
// PORTS
//  i_clk        in   1  system clock; all logic on rising edge
//  i_rstn       in   1  reset; one clock; asynchronous, active-low
//  i_uart_rx    in   1  raw RX pin, asynchronous to i_clk, idle high
//  o8_rxdata    out  8  last good byte received; held until the next good byte
//  o_valid      out  1  1-cycle strobe: o8_rxdata updated this cycle
//  o_frame_err  out  1  1-cycle strobe: stop bit sampled low; byte discarded
//  o_busy       out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): o8_rxdata=0, o_valid=0, o_frame_err=0, o_busy=0,
//   synchroniser flops=1 (idle), state=IDLE, timer=0, bit index=0.
//  Input: 2-FF synchroniser -> w_rx_s; a 3rd flop holds previous value for edge detect.
//  States:
//   IDLE   : timer=0. Falling edge on w_rx_s (prev 1, now 0) -> START.
//   START  : count to lp_HALF_PERIOD-1; at terminal count sample w_rx_s:
//            0 -> DATA (timer=0, index=0); 1 -> glitch, back to IDLE, no strobe.
//   DATA   : count 0..lp_BIT_PERIOD-1; at terminal count shift w_rx_s into bit[index]
//            (LSB first), index++; after 8th bit -> STOP.
//   STOP   : after one lp_BIT_PERIOD sample w_rx_s:
//            1 -> o8_rxdata<=shift reg, o_valid=1 for one cycle, -> IDLE.
//            0 -> o_frame_err=1 for one cycle, o8_rxdata unchanged, -> BRK_WAIT.
//   BRK_WAIT: stay until w_rx_s==1 (line break/hold-low tolerated), then -> IDLE.
//  o_busy = (state != IDLE). o_valid and o_frame_err never both high.
//  Latency: strobe occurs 2 (sync) + lp_HALF_PERIOD + 9*lp_BIT_PERIOD cycles (+-1) after
//   the falling pin edge, i.e. at mid stop bit; back-to-back frames with no idle gap
//   are received because IDLE is re-entered half a bit before the next start edge.
//  Tolerance: a transmitter period of lp_BIT_PERIOD+1 cycles must be received correctly.
//  Timer width = $clog2(lp_BIT_PERIOD); timer always reset to 0 on state change.
//  Falling edges during START/DATA/STOP are ignored (no resync mid-frame).
//  Reset mid-frame: frame abandoned, no strobe; after release, line must be seen high
//   (sync flops reset to 1) before a new start is accepted.
// STRUCTURE
//  Shared include uart_defs.vh: frame constants (8 data bits, 1 stop bit, start=0,
//   stop=1) and bit-period calculation used by both transmitter and receiver.
//  State encodings stay local to this module.
//  One sub-module: uart_rx_sync -- 2-FF synchroniser, reset-to-1, async active-low reset.
// TESTING (bench params p_CLK_FREQ=1_000_000, p_BAUDRATE=100_000 -> period 10 cycles)
//  1 Frame 0x55, 10-cycle bits -> one o_valid pulse, o8_rxdata=0x55, o_frame_err=0.
//  2 0xA3 then 0x00 back-to-back, no idle gap -> two o_valid pulses, data 0xA3 then 0x00.
//  3 RX low for 3 cycles then high -> no strobe, o_busy returns 0 within 5 cycles.
//  4 0x7E with stop bit low, then line low 30 cycles, then 0x12 -> one o_frame_err,
//    o8_rxdata keeps prior value, o_busy high through break, then o_valid with 0x12.
//  5 i_rstn low during data bit 4 -> all outputs 0 immediately; release, send 0xC3 ->
//    o_valid with 0xC3, no spurious strobe from the aborted frame.
//  6 Loopback with the transmitter at same params, bytes 0x00..0xFF -> 256 o_valid
//    pulses in order, data match, zero o_frame_err.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Frame constants and bit-period calculation for the board UART. Both the
// transmitter and the receiver import this package, so the two sides always
// agree on the frame shape and on the bit timing.
//   DATA_BITS : data bits per frame, sent LSB first
//   STOP_BITS : stop bits per frame
//   START_BIT : line level of the start bit
//   STOP_BIT  : line level of the stop bit (and of the idle line)
//   bit_period(): clock cycles per bit, rounded down
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int   DATA_BITS = 8;
  localparam int   STOP_BITS = 1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Rounds down. The receiver needs at least 4 cycles per bit so that the
  // half-bit delay of the start bit is not empty.
  function automatic int bit_period(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous RX pin. Both flops reset to 1,
// which is the idle line level, so a reset never looks like a start edge.
//   i_clk   : system clock
//   i_rstn  : asynchronous active-low reset
//   i_async : raw pin, asynchronous to i_clk
//   o_sync  : pin value synchronised to i_clk, two cycles of latency
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      meta   <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver. The frame is 1 start bit, 8 data bits sent
// LSB first, 1 stop bit, and no parity. The receiver confirms the start bit
// at its midpoint and then samples every later bit at its midpoint. A good
// byte is presented with a one-cycle valid strobe. If the stop bit is low,
// the receiver raises a framing-error strobe and waits for the line to
// return high before it accepts another frame.
//   i_clk       : system clock, rising edge
//   i_rstn      : asynchronous active-low reset
//   i_uart_rx   : raw RX pin, idle high
//   o8_rxdata   : last good byte, held until the next good byte
//   o_valid     : one-cycle strobe, o8_rxdata updated
//   o_frame_err : one-cycle strobe, stop bit low and byte discarded
//   o_busy      : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int p_BAUDRATE = 9600,
  parameter int p_CLK_FREQ = 12_000_000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_uart_rx,
  output logic [7:0] o8_rxdata,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int lp_BIT_PERIOD  = bit_period(p_CLK_FREQ, p_BAUDRATE);
  localparam int lp_HALF_PERIOD = lp_BIT_PERIOD / 2;
  localparam int lp_TIMER_W     = $clog2(lp_BIT_PERIOD);
  localparam int lp_IDX_W       = $clog2(DATA_BITS);

  localparam logic [lp_TIMER_W-1:0] lp_BIT_LAST  = lp_TIMER_W'(lp_BIT_PERIOD - 1);
  localparam logic [lp_TIMER_W-1:0] lp_HALF_LAST = lp_TIMER_W'(lp_HALF_PERIOD - 1);
  localparam logic [lp_IDX_W-1:0]   lp_IDX_LAST  = lp_IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  state_t                  state, state_n;
  logic [lp_TIMER_W-1:0]   timer, timer_n;
  logic [lp_IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]    shift, shift_n;
  logic [DATA_BITS-1:0]    rxdata, rxdata_n;
  logic                    valid_n, frame_err_n;
  logic                    rx_s, rx_prev;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_async (i_uart_rx),
    .o_sync  (rx_s)
  );

  // This flop keeps the previous synchronised value for falling-edge
  // detection. It resets to 1, so after a reset the line must be seen high
  // before a new start bit is accepted.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) rx_prev <= 1'b1;
    else         rx_prev <= rx_s;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rxdata      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      rxdata      <= rxdata_n;
      o_valid     <= valid_n;
      o_frame_err <= frame_err_n;
    end
  end

  // Every state transition clears the timer, so each state counts from zero.
  // Falling edges are only watched in IDLE. The receiver never
  // resynchronises in the middle of a frame.
  always_comb begin
    state_n     = state;
    timer_n     = timer + 1'b1;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    rxdata_n    = rxdata;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (rx_prev && !rx_s) state_n = S_START;
      end

      S_START: begin
        // Check the start bit again at its midpoint. A high line here means
        // the edge was a glitch.
        if (timer == lp_HALF_LAST) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = (rx_s == START_BIT) ? S_DATA : S_IDLE;
        end
      end

      S_DATA: begin
        if (timer == lp_BIT_LAST) begin
          timer_n          = '0;
          shift_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 1'b1;
          if (bit_idx == lp_IDX_LAST) state_n = S_STOP;
        end
      end

      S_STOP: begin
        if (timer == lp_BIT_LAST) begin
          timer_n = '0;
          if (rx_s == STOP_BIT) begin
            rxdata_n = shift;
            valid_n  = 1'b1;
            state_n  = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_BRK_WAIT;
          end
        end
      end

      S_BRK_WAIT: begin
        // Wait out a break or a line held low. A start bit is accepted again
        // only after the line has returned high.
        timer_n = '0;
        if (rx_s) state_n = S_IDLE;
      end

      default: begin
        timer_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign o8_rxdata = rxdata;
  assign o_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx at 1 MHz / 100 kbaud, which gives 10 clock cycles per
// bit. The bench acts as the transmitter. It drives whole frames onto the
// line and records every byte it sends with a good stop bit. A monitor
// collects every strobe from the receiver, and the two lists are compared
// in order. Strobe latency, measured from the falling start edge, must land
// at the middle of the stop bit.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int ClkFreq   = 1_000_000;
  localparam int Baud      = 100_000;
  localparam int BitPeriod = ClkFreq / Baud;
  localparam int LatNom    = 2 + BitPeriod / 2 + 9 * BitPeriod;

  logic       i_clk     = 1'b0;
  logic       i_rstn    = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic [7:0] o8_rxdata;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int checksTotal  = 0;
  int checksPassed = 0;
  int cycleCount   = 0;
  int lastFall     = 0;
  int errSeen      = 0;
  int bothSeen     = 0;
  int expErr       = 0;

  byte unsigned expQ[$];
  byte unsigned gotQ[$];
  int           latQ[$];

  uart_rx #(
    .p_BAUDRATE (Baud),
    .p_CLK_FREQ (ClkFreq)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_uart_rx   (i_uart_rx),
    .o8_rxdata   (o8_rxdata),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Free-running cycle count for latency measurement.
  always @(posedge i_clk) cycleCount++;

  // Strobe monitor. It samples on the falling edge, away from the active
  // edge.
  always @(negedge i_clk) begin
    if (o_valid) begin
      gotQ.push_back(o8_rxdata);
      latQ.push_back(cycleCount - lastFall);
    end
    if (o_frame_err) errSeen++;
    if (o_valid && o_frame_err) bothSeen++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Sends one frame starting at the current falling edge. A frame with a
  // good stop bit is added to the list of bytes the receiver should
  // deliver.
  task automatic applyStimulus(input byte unsigned data, input bit stopBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_uart_rx = frame[i];
      if (i == 0) lastFall = cycleCount;
      repeat (BitPeriod) @(negedge i_clk);
    end
    if (stopBit) expQ.push_back(data);
  endtask

  task automatic idleLine(input int n);
    i_uart_rx = 1'b1;
    repeat (n) @(negedge i_clk);
  endtask

  // Compares the received bytes against the expected bytes in order. Every
  // strobe must fall in the middle of the stop bit, within one cycle of
  // the nominal latency.
  task automatic compareQueues(input string tag);
    int n;
    checkOutput({tag, " count"}, gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s byte%0d", tag, i), gotQ[i], expQ[i]);
    for (int i = 0; i < latQ.size(); i++)
      checkOutput($sformatf("%s latency%0d=%0d in window", tag, i, latQ[i]),
                  int'(latQ[i] >= LatNom - 1 && latQ[i] <= LatNom + 1), 1);
    gotQ.delete();
    expQ.delete();
    latQ.delete();
  endtask

  initial begin
    logic [7:0] partial;
    bit         stopBit;

    // Reset values
    repeat (3) @(negedge i_clk);
    checkOutput("reset rxdata", o8_rxdata, 0);
    checkOutput("reset valid", o_valid, 0);
    checkOutput("reset frame_err", o_frame_err, 0);
    checkOutput("reset busy", o_busy, 0);
    i_rstn = 1'b1;
    idleLine(5);

    // Single frame
    applyStimulus(8'h55, 1'b1);
    idleLine(10);
    compareQueues("t1");
    checkOutput("t1 frame_err", errSeen, 0);

    // Back-to-back frames with no idle gap
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'h00, 1'b1);
    idleLine(10);
    compareQueues("t2");

    // Start glitch three cycles long
    i_uart_rx = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("t3 busy on glitch", o_busy, 1);
    i_uart_rx = 1'b1;
    repeat (6) @(negedge i_clk);
    checkOutput("t3 busy cleared", o_busy, 0);
    compareQueues("t3");

    // Framing error, then a break on the line, then a good frame
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h7E, 1'b0);
    expErr++;
    i_uart_rx = 1'b0;
    repeat (15) @(negedge i_clk);
    checkOutput("t4 busy in break", o_busy, 1);
    checkOutput("t4 frame_err count", errSeen, expErr);
    checkOutput("t4 rxdata kept", o8_rxdata, 8'h3C);
    repeat (15) @(negedge i_clk);
    checkOutput("t4 busy end of break", o_busy, 1);
    idleLine(20);
    checkOutput("t4 busy after break", o_busy, 0);
    applyStimulus(8'h12, 1'b1);
    idleLine(10);
    compareQueues("t4");

    // Reset in the middle of data bit 4
    partial = 8'hA5;
    i_uart_rx = 1'b0;
    lastFall = cycleCount;
    repeat (BitPeriod) @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      i_uart_rx = partial[i];
      repeat (BitPeriod) @(negedge i_clk);
    end
    i_uart_rx = partial[4];
    repeat (BitPeriod / 2) @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    checkOutput("t5 rxdata in reset", o8_rxdata, 0);
    checkOutput("t5 valid in reset", o_valid, 0);
    checkOutput("t5 frame_err in reset", o_frame_err, 0);
    checkOutput("t5 busy in reset", o_busy, 0);
    i_uart_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    idleLine(10);
    applyStimulus(8'hC3, 1'b1);
    idleLine(10);
    compareQueues("t5");

    // Every byte value, sent back-to-back
    for (int b = 0; b < 256; b++) applyStimulus(byte'(b), 1'b1);
    idleLine(10);
    compareQueues("t6");
    checkOutput("t6 frame_err count", errSeen, expErr);

    // Random bytes, random idle gaps, occasional bad stop bits
    for (int i = 0; i < 24; i++) begin
      stopBit = ($urandom_range(0, 7) != 0);
      applyStimulus(byte'($urandom_range(0, 255)), stopBit);
      if (!stopBit) begin
        expErr++;
        i_uart_rx = 1'b0;
        repeat ($urandom_range(0, 20)) @(negedge i_clk);
        idleLine(12);
      end else begin
        idleLine($urandom_range(0, 4));
      end
    end
    idleLine(10);
    compareQueues("t7");
    checkOutput("t7 frame_err count", errSeen, expErr);
    checkOutput("valid and frame_err together", bothSeen, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
